debug_host_link: RTL and testbench

//  Host-side counterpart of the MIPS debug unit: sends command bytes over the UART byte interface and collects the returned dump frame.

---
 rtl/debug_pkg.sv | 40 ++++
 rtl/debug_word_assembler.sv | 60 ++++++
 rtl/debug_host_link.sv | 152 +++++++++++++++
 tb/tb_debug_host_link.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared debug-link definitions: command codes and bytes, host FSM states, frame layout.
// Used by the host link as well as the debug unit receive/transmit side.
package debug_pkg;

  localparam logic [1:0] CMD_RUN_CONTINUOUS  = 2'd0;
  localparam logic [1:0] CMD_ENTER_STEP_MODE = 2'd1;
  localparam logic [1:0] CMD_STEP            = 2'd2;
  localparam logic [1:0] CMD_RESERVED        = 2'd3;

  localparam logic [7:0] BYTE_RUN_CONTINUOUS  = 8'h43;
  localparam logic [7:0] BYTE_ENTER_STEP_MODE = 8'h53;
  localparam logic [7:0] BYTE_STEP            = 8'h4E;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND    = 3'd1,
    ST_WAIT_TX = 3'd2,
    ST_RECV    = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERROR   = 3'd5
  } host_state_e;

  // Word positions inside a dump frame; registers follow from WORD_REG0.
  localparam logic [5:0] WORD_PC     = 6'd0;
  localparam logic [5:0] WORD_CYCLES = 6'd1;
  localparam logic [5:0] WORD_DMEM   = 6'd2;
  localparam logic [5:0] WORD_REG0   = 6'd3;

  function automatic logic [7:0] cmd_to_byte(input logic [1:0] cmd);
    logic [7:0] b;
    case (cmd)
      CMD_RUN_CONTINUOUS:  b = BYTE_RUN_CONTINUOUS;
      CMD_ENTER_STEP_MODE: b = BYTE_ENTER_STEP_MODE;
      CMD_STEP:            b = BYTE_STEP;
      default:             b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/debug_word_assembler.sv
// Packs little-endian bytes into words; o_word_valid pulses the cycle after the last byte of a word.
// i_clear drops any partial word and restarts at byte 0.
module debug_word_assembler #(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_byte_valid,
  input  logic [NB_BYTE-1:0] i_byte,
  output logic [NB_DATA-1:0] o_word,
  output logic               o_word_valid
);

  localparam int N_BYTES = NB_DATA / NB_BYTE;
  localparam int NB_CNT  = $clog2(N_BYTES);
  localparam logic [NB_CNT-1:0] LAST_BYTE = NB_CNT'(N_BYTES - 1);

  logic [NB_CNT-1:0]  byte_cnt_q, byte_cnt_d;
  logic [NB_DATA-1:0] asm_q, asm_d;
  logic [NB_DATA-1:0] word_q, word_d;
  logic               word_valid_q, word_valid_d;

  always_comb begin
    byte_cnt_d   = byte_cnt_q;
    asm_d        = asm_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    if (i_clear) begin
      byte_cnt_d = '0;
      asm_d      = '0;
    end else if (i_byte_valid) begin
      asm_d[byte_cnt_q*NB_BYTE +: NB_BYTE] = i_byte;
      byte_cnt_d = byte_cnt_q + 1'b1;
      if (byte_cnt_q == LAST_BYTE) begin
        word_d       = asm_d;
        word_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      byte_cnt_q   <= byte_cnt_d;
      asm_q        <= asm_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign o_word       = word_q;
  assign o_word_valid = word_valid_q;

endmodule

// File: rtl/debug_host_link.sv
// Host side of the debug link: sends one command byte, then reassembles the returned dump frame.
// o_pc/o_cycles only change when a whole frame arrives; a timeout or reset discards the partial frame.
module debug_host_link
  import debug_pkg::*;
#(
  parameter int NB_DATA        = 32,
  parameter int NB_BYTE        = 8,
  parameter int N_REGISTERS    = 32,
  parameter int N_WORDS        = 3 + N_REGISTERS,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int NB_STATE       = 3
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_cmd_valid,
  input  logic [1:0]          i_cmd,
  output logic                o_cmd_ready,
  output logic [NB_BYTE-1:0]  o_uart_tx_data,
  output logic                o_uart_tx_start,
  input  logic                i_uart_tx_done,
  input  logic [NB_BYTE-1:0]  i_uart_rx_data,
  input  logic                i_uart_rx_done,
  output logic [NB_DATA-1:0]  o_word,
  output logic                o_word_valid,
  output logic [5:0]          o_word_index,
  output logic [NB_DATA-1:0]  o_pc,
  output logic [NB_DATA-1:0]  o_cycles,
  output logic                o_frame_done,
  output logic                o_error,
  output logic [NB_STATE-1:0] o_state
);

  localparam int NB_TIMER = $clog2(TIMEOUT_CYCLES);
  localparam logic [NB_TIMER-1:0] TIMER_MAX = NB_TIMER'(TIMEOUT_CYCLES - 1);
  localparam logic [5:0]          LAST_WORD = 6'(N_WORDS - 1);

  host_state_e         state_q, state_d;
  logic [NB_BYTE-1:0]  tx_byte_q, tx_byte_d;
  logic [NB_TIMER-1:0] timer_q, timer_d;
  logic [5:0]          word_cnt_q, word_cnt_d;
  logic [NB_DATA-1:0]  pc_shadow_q, pc_shadow_d, cycles_shadow_q, cycles_shadow_d;
  logic [NB_DATA-1:0]  pc_q, pc_d, cycles_q, cycles_d;

  logic               asm_clear;
  logic               asm_byte_valid;
  logic [NB_DATA-1:0] asm_word;
  logic               asm_word_valid;

  assign asm_byte_valid = (state_q == ST_RECV) && i_uart_rx_done;

  debug_word_assembler #(.NB_DATA(NB_DATA), .NB_BYTE(NB_BYTE)) u_asm (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_clear      (asm_clear),
    .i_byte_valid (asm_byte_valid),
    .i_byte       (i_uart_rx_data),
    .o_word       (asm_word),
    .o_word_valid (asm_word_valid)
  );

  always_comb begin
    state_d         = state_q;
    tx_byte_d       = tx_byte_q;
    timer_d         = timer_q;
    word_cnt_d      = word_cnt_q;
    pc_shadow_d     = pc_shadow_q;
    cycles_shadow_d = cycles_shadow_q;
    pc_d            = pc_q;
    cycles_d        = cycles_q;
    asm_clear       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid && (i_cmd != CMD_RESERVED)) begin
          tx_byte_d = cmd_to_byte(i_cmd);
          state_d   = ST_SEND;
        end
      end
      ST_SEND: state_d = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (i_uart_tx_done) begin
          if (tx_byte_q == BYTE_ENTER_STEP_MODE) begin
            state_d = ST_IDLE;
          end else begin
            state_d    = ST_RECV;
            timer_d    = '0;
            word_cnt_d = '0;
            asm_clear  = 1'b1;
          end
        end
      end
      ST_RECV: begin
        if (asm_word_valid) begin
          if (word_cnt_q == WORD_PC)     pc_shadow_d     = asm_word;
          if (word_cnt_q == WORD_CYCLES) cycles_shadow_d = asm_word;
          if (word_cnt_q == LAST_WORD) begin
            pc_d     = pc_shadow_q;
            cycles_d = cycles_shadow_q;
            state_d  = ST_DONE;
          end else begin
            word_cnt_d = word_cnt_q + 6'd1;
          end
        end
        // A byte arriving on the expiry cycle still counts and restarts the timer.
        if (i_uart_rx_done) begin
          timer_d = '0;
        end else if (timer_q == TIMER_MAX) begin
          if (state_d == ST_RECV) state_d = ST_ERROR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q         <= ST_IDLE;
      tx_byte_q       <= '0;
      timer_q         <= '0;
      word_cnt_q      <= '0;
      pc_shadow_q     <= '0;
      cycles_shadow_q <= '0;
      pc_q            <= '0;
      cycles_q        <= '0;
    end else begin
      state_q         <= state_d;
      tx_byte_q       <= tx_byte_d;
      timer_q         <= timer_d;
      word_cnt_q      <= word_cnt_d;
      pc_shadow_q     <= pc_shadow_d;
      cycles_shadow_q <= cycles_shadow_d;
      pc_q            <= pc_d;
      cycles_q        <= cycles_d;
    end
  end

  assign o_cmd_ready     = (state_q == ST_IDLE);
  assign o_uart_tx_start = (state_q == ST_SEND);
  assign o_uart_tx_data  = tx_byte_q;
  assign o_word          = asm_word;
  assign o_word_valid    = asm_word_valid;
  assign o_word_index    = word_cnt_q;
  assign o_pc            = pc_q;
  assign o_cycles        = cycles_q;
  assign o_frame_done    = (state_q == ST_DONE);
  assign o_error         = (state_q == ST_ERROR);
  assign o_state         = NB_STATE'(state_q);

endmodule

// File: tb/tb_debug_host_link.sv
// Bench for debug_host_link: command table, directed frame/timeout/reset sequences, random commands and frames.
module tb_debug_host_link;
  import debug_pkg::*;

  localparam int TO = 100;
  localparam int NW = 35;
  localparam int NB = 4 * NW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, cmd_vld, tx_done, rx_done;
  logic [1:0]  cmd;
  logic [7:0]  rx_dat, tx_dat;
  logic        cmd_rdy, tx_start, word_vld, fdone, err;
  logic [31:0] word, pc, cyc;
  logic [5:0]  widx;
  logic [2:0]  st;

  debug_host_link #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_cmd_valid(cmd_vld), .i_cmd(cmd),
    .o_cmd_ready(cmd_rdy), .o_uart_tx_data(tx_dat), .o_uart_tx_start(tx_start),
    .i_uart_tx_done(tx_done), .i_uart_rx_data(rx_dat), .i_uart_rx_done(rx_done),
    .o_word(word), .o_word_valid(word_vld), .o_word_index(widx),
    .o_pc(pc), .o_cycles(cyc), .o_frame_done(fdone), .o_error(err), .o_state(st)
  );

  int checks = 0;
  int errors = 0;
  int n_start = 0, n_fdone = 0, n_err = 0;
  logic [31:0] w_dat[$];
  logic [5:0]  w_idx[$];
  logic [7:0]  fb[$];
  logic [31:0] m_pc = '0, m_cyc = '0;

  always @(negedge clk) begin
    if (tx_start) n_start++;
    if (fdone) n_fdone++;
    if (err) n_err++;
    if (word_vld) begin
      w_dat.push_back(word);
      w_idx.push_back(widx);
    end
  end

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] tx_byte;
    logic       start;
    logic [2:0] st_after;
    logic       frame;
  } vec_t;
  vec_t tv[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] c, input int dly);
    cmd_vld = 1'b1; cmd = c;
    tick();
    cmd_vld = 1'b0; cmd = 2'd0;
    repeat (dly) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_dat = b; rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    fb.push_back(b);
  endtask

  task automatic feed(input int n, input bit seq, input int gapmax);
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat ($urandom_range(0, gapmax)) tick();
      send_byte(seq ? 8'(fb.size()) : 8'($urandom));
    end
  endtask

  // Reference: word k of the frame is bytes 4k..4k+3, least significant first.
  task automatic check_words(input int base, input int nwords);
    logic [31:0] exp;
    for (int k = 0; k < nwords; k++) begin
      exp = {fb[4*k+3], fb[4*k+2], fb[4*k+1], fb[4*k]};
      if (base + k < w_dat.size()) begin
        chk($sformatf("word%0d", k), w_dat[base+k], exp);
        chk($sformatf("index%0d", k), 32'(w_idx[base+k]), k);
      end else begin
        chk($sformatf("word%0d_present", k), w_dat.size(), base + k + 1);
      end
    end
  endtask

  // Called right after the last byte of a frame has been sampled.
  task automatic finish_frame(input int base);
    int f0;
    f0 = n_fdone;
    chk("last_word_vld", 32'(word_vld), 1);
    chk("last_word_idx", 32'(widx), NW - 1);
    tick();
    chk("frame_done", 32'(fdone), 1);
    m_pc  = {fb[3], fb[2], fb[1], fb[0]};
    m_cyc = {fb[7], fb[6], fb[5], fb[4]};
    chk("o_pc", pc, m_pc);
    chk("o_cycles", cyc, m_cyc);
    tick();
    chk("frame_end_state", 32'(st), 0);
    chk("frame_end_ready", 32'(cmd_rdy), 1);
    chk("frame_done_count", n_fdone - f0, 1);
    chk("word_count", w_dat.size() - base, NW);
    check_words(base, NW);
  endtask

  task automatic full_frame(input logic [1:0] c, input bit seq, input int gapmax);
    int base;
    fb.delete();
    base = w_dat.size();
    issue(c, $urandom_range(1, 12));
    chk("recv_state", 32'(st), 3);
    feed(NB, seq, gapmax);
    finish_frame(base);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, s0, s1, e0, f0, cnt, w0;
    logic [1:0] c;

    tv[0] = '{CMD_RUN_CONTINUOUS,  8'h43, 1'b1, 3'd3, 1'b1};
    tv[1] = '{CMD_ENTER_STEP_MODE, 8'h53, 1'b1, 3'd0, 1'b0};
    tv[2] = '{CMD_STEP,            8'h4E, 1'b1, 3'd3, 1'b1};
    tv[3] = '{CMD_RESERVED,        8'h00, 1'b0, 3'd0, 1'b0};

    rst_n = 1'b0; cmd_vld = 1'b0; cmd = 2'd0; tx_done = 1'b0; rx_done = 1'b0; rx_dat = 8'h00;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_ready", 32'(cmd_rdy), 1);
    chk("rst_state", 32'(st), 0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_tx_data", 32'(tx_dat), 0);
    chk("rst_word", word, 0);
    chk("rst_word_vld", 32'(word_vld), 0);
    chk("rst_pc", pc, 0);
    chk("rst_cycles", cyc, 0);
    chk("rst_fdone_err", {30'd0, fdone, err}, 0);

    // Sequential 00..8B frame after a STEP
    fb.delete();
    base = w_dat.size();
    issue(CMD_STEP, 10);
    feed(NB, 1'b1, 0);
    finish_frame(base);
    if (w_dat.size() > base + NW - 1) begin
      chk("seq_word0", w_dat[base], 32'h03020100);
      chk("seq_word34", w_dat[base+NW-1], 32'h8B8A8988);
    end else begin
      chk("seq_words_present", w_dat.size(), base + NW);
    end

    // Command table
    for (int i = 0; i < 4; i++) begin
      s0 = n_start;
      fb.delete();
      base = w_dat.size();
      cmd_vld = 1'b1; cmd = tv[i].cmd;
      tick();
      cmd_vld = 1'b0; cmd = 2'd0;
      chk($sformatf("v%0d_tx_start", i), 32'(tx_start), 32'(tv[i].start));
      chk($sformatf("v%0d_ready", i), 32'(cmd_rdy), 32'(!tv[i].start));
      if (tv[i].start) chk($sformatf("v%0d_tx_data", i), 32'(tx_dat), 32'(tv[i].tx_byte));
      repeat (4) tick();
      if (tv[i].start) chk($sformatf("v%0d_tx_data_hold", i), 32'(tx_dat), 32'(tv[i].tx_byte));
      tx_done = tv[i].start;
      tick();
      tx_done = 1'b0;
      chk($sformatf("v%0d_state_after", i), 32'(st), 32'(tv[i].st_after));
      chk($sformatf("v%0d_start_count", i), n_start - s0, 32'(tv[i].start));
      if (tv[i].frame) begin
        feed(NB, 1'b0, 2);
        finish_frame(base);
      end
    end

    // Timeout abort, with a byte landing exactly on the expiry cycle first
    fb.delete();
    base = w_dat.size();
    e0 = n_err;
    issue(CMD_STEP, 3);
    feed(4, 1'b0, 0);
    repeat (TO - 1) tick();
    send_byte(8'($urandom));
    chk("byte_wins_state", 32'(st), 3);
    chk("byte_wins_no_err", n_err - e0, 0);
    send_byte(8'($urandom));
    cnt = 0;
    while (err !== 1'b1 && cnt < 3 * TO) begin
      tick();
      cnt++;
    end
    chk("timeout_latency", cnt, TO);
    chk("timeout_pc_kept", pc, m_pc);
    chk("timeout_cycles_kept", cyc, m_cyc);
    tick();
    chk("timeout_err_one_cycle", 32'(err), 0);
    chk("timeout_ready", 32'(cmd_rdy), 1);
    chk("timeout_err_count", n_err - e0, 1);
    chk("timeout_words", w_dat.size() - base, 1);

    // Reset in the middle of a frame
    f0 = n_fdone;
    e0 = n_err;
    fb.delete();
    issue(CMD_STEP, 2);
    feed(50, 1'b0, 1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_ready", 32'(cmd_rdy), 1);
    chk("mid_rst_state", 32'(st), 0);
    chk("mid_rst_word", word, 0);
    chk("mid_rst_pc", pc, 0);
    chk("mid_rst_cycles", cyc, 0);
    chk("mid_rst_tx_data", 32'(tx_dat), 0);
    chk("mid_rst_index", 32'(widx), 0);
    rst_n = 1'b1;
    m_pc = '0; m_cyc = '0;
    repeat (2) tick();
    chk("mid_rst_no_pulses", (n_fdone - f0) + (n_err - e0), 0);
    full_frame(CMD_STEP, 1'b0, 2);

    // Commands offered during RECV are ignored
    fb.delete();
    base = w_dat.size();
    issue(CMD_STEP, 4);
    s1 = n_start;
    cmd_vld = 1'b1; cmd = CMD_ENTER_STEP_MODE;
    feed(NB - 4, 1'b0, 1);
    cmd_vld = 1'b0; cmd = 2'd0;
    feed(4, 1'b0, 0);
    finish_frame(base);
    chk("no_start_in_recv", n_start - s1, 0);

    // Stray bytes while idle produce nothing
    w0 = w_dat.size();
    for (int i = 0; i < 6; i++) send_byte(8'($urandom));
    tick();
    chk("stray_rx_words", w_dat.size() - w0, 0);
    chk("stray_rx_state", 32'(st), 0);

    // Random command mix against the model
    for (int r = 0; r < 6; r++) begin
      c = 2'($urandom_range(0, 3));
      s0 = n_start;
      if (c == CMD_RESERVED) begin
        cmd_vld = 1'b1; cmd = c;
        tick();
        cmd_vld = 1'b0;
        tick();
        chk("rand_reserved_ready", 32'(cmd_rdy), 1);
        chk("rand_reserved_starts", n_start - s0, 0);
      end else if (c == CMD_ENTER_STEP_MODE) begin
        issue(c, $urandom_range(1, 8));
        chk("rand_esm_state", 32'(st), 0);
        chk("rand_esm_byte", 32'(tx_dat), 32'h53);
        chk("rand_esm_starts", n_start - s0, 1);
      end else begin
        full_frame(c, 1'b0, 2);
        chk("rand_frame_byte", 32'(tx_dat), 32'(cmd_to_byte(c)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
